// File: rtl/portb_change_detect.sv
// PORTB input-side reader: synchronises the raw pins, detects RB0/INT edges
// and RB7:RB4 interrupt-on-change mismatches, and holds INTF/RBIF until the
// core clears them through INTCON writes.
module portb_change_detect #(
    parameter int SYNC_STAGES = 2,
    parameter int WARMUP      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] physical_in,
    input  logic [7:0] tris,
    input  logic       port_rd_en,
    input  logic       intedg,
    input  logic [1:0] flag_in,
    input  logic       flag_wr_en,
    output logic [7:0] pin_sync,
    output logic       intf,
    output logic       rbif
);

    logic [7:0] sync_q [SYNC_STAGES];
    logic [2:0] warm_cnt;
    logic       prev0;
    logic [3:0] chg_latch;
    logic       warming;
    logic       set_int;
    logic       set_rb;

    // RB3:RB1 direction bits have no role on the input/interrupt side.
    logic       unused_tris;
    assign unused_tris = ^tris[3:1];

    assign pin_sync = sync_q[SYNC_STAGES-1];

    // Multi-flop synchroniser per pin; reset discards any edge in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 8'h00;
            end
        end else begin
            sync_q[0] <= physical_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Warm-up countdown; detection stays disabled until it reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= 3'(WARMUP);
        end else if (warm_cnt != 3'd0) begin
            warm_cnt <= warm_cnt - 3'd1;
        end
    end

    // Edge/mismatch detection from the synchronised pins and the stored history.
    always_comb begin
        warming = (warm_cnt != 3'd0);
        set_int = 1'b0;
        if (!warming && tris[0]) begin
            if (intedg) begin
                set_int = !prev0 && pin_sync[0];
            end else begin
                set_int = prev0 && !pin_sync[0];
            end
        end
        set_rb = !warming && (|(tris[7:4] & (pin_sync[7:4] ^ chg_latch)));
    end

    // RB0 history and the RB7:RB4 change latch; warm-up tracks the pins so
    // levels present at reset release never look like a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev0     <= 1'b0;
            chg_latch <= 4'h0;
        end else begin
            prev0 <= pin_sync[0];
            if (warming || port_rd_en) begin
                chg_latch <= pin_sync[7:4];
            end
        end
    end

    // Sticky flags: hardware set beats a simultaneous software write.
    always_ff @(posedge clk) begin
        if (rst) begin
            intf <= 1'b0;
            rbif <= 1'b0;
        end else begin
            if (set_int) begin
                intf <= 1'b1;
            end else if (flag_wr_en) begin
                intf <= flag_in[0];
            end
            if (set_rb) begin
                rbif <= 1'b1;
            end else if (flag_wr_en) begin
                rbif <= flag_in[1];
            end
        end
    end

endmodule

// File: tb/tb_portb_change_detect.sv
// Self-checking bench for portb_change_detect: directed scenarios plus a
// randomized run checked against a cycle-level reference model.
module tb_portb_change_detect;

    localparam int SYNC_STAGES = 2;
    localparam int WARMUP      = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] physical_in;
    logic [7:0] tris;
    logic       port_rd_en;
    logic       intedg;
    logic [1:0] flag_in;
    logic       flag_wr_en;
    logic [7:0] pin_sync;
    logic       intf;
    logic       rbif;

    int checks   = 0;
    int failures = 0;

    // Reference model state: pin history, warm-up count, RB0 history, latch, flags.
    logic [7:0] m_hist [$];
    logic [7:0] m_sync;
    int         m_cnt;
    logic       m_prev0;
    logic [3:0] m_latch;
    logic       m_intf;
    logic       m_rbif;

    portb_change_detect #(
        .SYNC_STAGES(SYNC_STAGES),
        .WARMUP     (WARMUP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .physical_in(physical_in),
        .tris       (tris),
        .port_rd_en (port_rd_en),
        .intedg     (intedg),
        .flag_in    (flag_in),
        .flag_wr_en (flag_wr_en),
        .pin_sync   (pin_sync),
        .intf       (intf),
        .rbif       (rbif)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Advance one clock; the model applies the rules to the inputs present at the edge.
    task automatic tick();
        logic       n_intf, n_rbif, n_prev0, edge_seen, mism;
        logic [3:0] n_latch;
        int         n_cnt;
        if (rst) begin
            m_hist.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(8'h00);
            n_cnt   = WARMUP;
            n_prev0 = 1'b0;
            n_latch = 4'h0;
            n_intf  = 1'b0;
            n_rbif  = 1'b0;
        end else begin
            edge_seen = 1'b0;
            mism      = 1'b0;
            if (m_cnt == 0 && tris[0]) begin
                if (intedg) edge_seen = (m_prev0 == 1'b0) && (m_sync[0] == 1'b1);
                else        edge_seen = (m_prev0 == 1'b1) && (m_sync[0] == 1'b0);
            end
            if (m_cnt == 0) begin
                for (int i = 4; i < 8; i++) begin
                    if (tris[i] && (m_sync[i] != m_latch[i-4])) mism = 1'b1;
                end
            end
            n_intf  = edge_seen ? 1'b1 : (flag_wr_en ? flag_in[0] : m_intf);
            n_rbif  = mism      ? 1'b1 : (flag_wr_en ? flag_in[1] : m_rbif);
            n_prev0 = m_sync[0];
            n_latch = (m_cnt != 0 || port_rd_en) ? m_sync[7:4] : m_latch;
            n_cnt   = (m_cnt > 0) ? m_cnt - 1 : 0;
            m_hist.push_back(physical_in);
            void'(m_hist.pop_front());
        end
        @(posedge clk);
        #1;
        m_sync  = m_hist[0];
        m_cnt   = n_cnt;
        m_prev0 = n_prev0;
        m_latch = n_latch;
        m_intf  = n_intf;
        m_rbif  = n_rbif;
    endtask

    task automatic test_reset();
        physical_in = 8'hFF;
        tris        = 8'hFF;
        rst         = 1'b1;
        repeat (3) tick();
        checks++;
        if (intf !== 1'b0 || rbif !== 1'b0 || pin_sync !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_state: intf=%b rbif=%b pin_sync=%h, required 0 0 00", intf, rbif, pin_sync);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (intf !== 1'b0 || rbif !== 1'b0) begin
                failures++;
                $display("[TB] FAIL warmup_flags cycle %0d: intf=%b rbif=%b, required 0 0", i, intf, rbif);
            end
            if (i == SYNC_STAGES - 1) begin
                checks++;
                if (pin_sync !== 8'hFF) begin
                    failures++;
                    $display("[TB] FAIL warmup_pin_sync: got %h, required ff", pin_sync);
                end
            end
        end
    endtask

    task automatic test_rising_int();
        intedg      = 1'b1;
        physical_in = 8'hFE;
        repeat (4) tick();
        physical_in = 8'hFF;
        tick();
        tick();
        checks++;
        if (pin_sync[0] !== 1'b1 || intf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rise_t2: pin_sync0=%b intf=%b, required 1 0", pin_sync[0], intf);
        end
        tick();
        checks++;
        if (intf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rise_t3: intf=%b, required 1", intf);
        end
        repeat (3) tick();
        checks++;
        if (intf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rise_hold: intf=%b, required 1", intf);
        end
        flag_wr_en = 1'b1;
        flag_in    = 2'b00;
        tick();
        flag_wr_en = 1'b0;
        checks++;
        if (intf !== 1'b0 || rbif !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rise_clear: intf=%b rbif=%b, required 0 0", intf, rbif);
        end
    endtask

    task automatic test_polarity();
        intedg      = 1'b0;
        physical_in = 8'hFE;
        repeat (3) tick();
        checks++;
        if (intf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fall_edge: intf=%b, required 1", intf);
        end
        flag_wr_en = 1'b1;
        flag_in    = 2'b00;
        tick();
        flag_wr_en = 1'b0;
        physical_in = 8'hFF;
        repeat (4) tick();
        checks++;
        if (intf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rise_ignored: intf=%b, required 0", intf);
        end
        tris        = 8'hFE;
        physical_in = 8'hFE;
        repeat (4) tick();
        physical_in = 8'hFF;
        repeat (4) tick();
        checks++;
        if (intf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tris0_block: intf=%b, required 0", intf);
        end
        tris   = 8'hFF;
        intedg = 1'b1;
        repeat (3) tick();
        intedg = 1'b0;
        repeat (3) tick();
        checks++;
        if (intf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL intedg_toggle: intf=%b, required 0", intf);
        end
    endtask

    task automatic test_ioc();
        tris        = 8'hF0;
        physical_in = 8'h00;
        repeat (4) tick();
        port_rd_en = 1'b1;
        tick();
        port_rd_en = 1'b0;
        flag_wr_en = 1'b1;
        flag_in    = 2'b00;
        tick();
        flag_wr_en = 1'b0;
        checks++;
        if (rbif !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ioc_idle: rbif=%b, required 0", rbif);
        end
        physical_in = 8'h20;
        tick();
        tick();
        checks++;
        if (rbif !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ioc_t2: rbif=%b, required 0", rbif);
        end
        tick();
        checks++;
        if (rbif !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ioc_t3: rbif=%b, required 1", rbif);
        end
        flag_wr_en = 1'b1;
        flag_in    = 2'b00;
        tick();
        flag_wr_en = 1'b0;
        checks++;
        if (rbif !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ioc_clear_mismatched: rbif=%b, required 1", rbif);
        end
        port_rd_en = 1'b1;
        tick();
        port_rd_en = 1'b0;
        checks++;
        if (rbif !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ioc_same_cycle_read: rbif=%b, required 1", rbif);
        end
        flag_wr_en = 1'b1;
        flag_in    = 2'b00;
        tick();
        flag_wr_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rbif !== 1'b0) begin
                failures++;
                $display("[TB] FAIL ioc_after_read cycle %0d: rbif=%b, required 0", i, rbif);
            end
            tick();
        end
    endtask

    task automatic test_output_mask();
        tris = 8'h0F;
        for (int i = 0; i < 20; i++) begin
            physical_in = {4'($urandom_range(0, 15)), 4'h0};
            tick();
            checks++;
            if (rbif !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mask_toggle cycle %0d: rbif=%b, required 0", i, rbif);
            end
        end
        physical_in = 8'hF0;
        repeat (3) tick();
        checks++;
        if (rbif !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mask_settled: rbif=%b, required 0", rbif);
        end
        tris = 8'hFF;
        tick();
        checks++;
        if (rbif !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mask_to_input: rbif=%b, required 1", rbif);
        end
    endtask

    task automatic test_collision_reset();
        intedg      = 1'b1;
        physical_in = 8'hF1;
        tick();
        tick();
        flag_wr_en = 1'b1;
        flag_in    = 2'b00;
        tick();
        flag_wr_en = 1'b0;
        checks++;
        if (intf !== 1'b1 || rbif !== 1'b1) begin
            failures++;
            $display("[TB] FAIL collision: intf=%b rbif=%b, required 1 1", intf, rbif);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (intf !== 1'b0 || rbif !== 1'b0 || pin_sync !== 8'h00) begin
            failures++;
            $display("[TB] FAIL mid_reset: intf=%b rbif=%b pin_sync=%h, required 0 0 00", intf, rbif, pin_sync);
        end
        for (int i = 0; i < WARMUP + 3; i++) begin
            tick();
            checks++;
            if (intf !== 1'b0 || rbif !== 1'b0) begin
                failures++;
                $display("[TB] FAIL post_reset_warmup cycle %0d: intf=%b rbif=%b, required 0 0", i, intf, rbif);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            physical_in = 8'($urandom);
            tris        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : tris;
            port_rd_en  = ($urandom_range(0, 5) == 0);
            intedg      = ($urandom_range(0, 15) == 0) ? ~intedg : intedg;
            flag_wr_en  = ($urandom_range(0, 7) == 0);
            flag_in     = 2'($urandom);
            rst         = ($urandom_range(0, 59) == 0);
            tick();
            checks++;
            if (pin_sync !== m_sync || intf !== m_intf || rbif !== m_rbif) begin
                failures++;
                $display("[TB] FAIL random cycle %0d: pin_sync=%h intf=%b rbif=%b, required %h %b %b",
                         i, pin_sync, intf, rbif, m_sync, m_intf, m_rbif);
            end
        end
        rst        = 1'b0;
        port_rd_en = 1'b0;
        flag_wr_en = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        physical_in = 8'h00;
        tris        = 8'hFF;
        port_rd_en  = 1'b0;
        intedg      = 1'b1;
        flag_in     = 2'b00;
        flag_wr_en  = 1'b0;
        m_sync      = 8'h00;
        m_cnt       = WARMUP;
        m_prev0     = 1'b0;
        m_latch     = 4'h0;
        m_intf      = 1'b0;
        m_rbif      = 1'b0;
        for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(8'h00);
        #2;
        test_reset();
        test_rising_int();
        test_polarity();
        test_ioc();
        test_output_mask();
        test_collision_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
